sprite_attr_bank: RTL and testbench

- Parametrised successor to the per-sprite PIO exports (x/y/en per object). One Avalon-MM slave replaces N separate PIOs.
- Holds NUM_SPRITES position/attribute entries in CPU-writable shadow registers. Commits them atomically to the active outputs at a frame boundary, so the VGA compositor never sees a half-updated scene.
- Sits between the Nios bus and the sprite compositor.

---
 rtl/sprite_bank_pkg.sv | 33 +++
 rtl/sprite_attr_bank_entry.sv | 77 +++++++
 rtl/sprite_attr_bank.sv | 166 ++++++++++++++++
 tb/tb_sprite_attr_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_bank_pkg.sv
// Shared constants and types for the sprite attribute bank.
// Register map, CTRL/STATUS bit positions and the widest per-sprite record.
package sprite_bank_pkg;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_STATUS   = 1;
  localparam int unsigned ADDR_FCOUNT   = 2;
  localparam int unsigned ADDR_SPR_BASE = 4;

  localparam int unsigned CTRL_AUTO_BIT   = 0;
  localparam int unsigned CTRL_COMMIT_BIT = 1;
  localparam int unsigned CTRL_IRQEN_BIT  = 2;

  localparam int unsigned STAT_PEND_BIT = 0;
  localparam int unsigned STAT_IRQ_BIT  = 1;

  // Fields sized for the largest legal COORD_W/FLAG_W; narrower builds zero-extend.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        en;
    logic [14:0] flags;
  } sprite_attr_t;

  function automatic int unsigned pos_addr(input int unsigned idx);
    return ADDR_SPR_BASE + 2 * idx;
  endfunction

  function automatic int unsigned attr_addr(input int unsigned idx);
    return ADDR_SPR_BASE + 2 * idx + 1;
  endfunction

endpackage

// File: rtl/sprite_attr_bank_entry.sv
// One sprite: CPU-visible shadow registers plus the active copy that the
// compositor sees. Commit copies the shadow as it stood before this edge.
module sprite_entry
  import sprite_bank_pkg::*;
#(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned FLAG_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_pos_i,
  input  logic               wr_attr_i,
  input  logic               commit_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               en_i,
  input  logic [FLAG_W-1:0]  flags_i,
  output sprite_attr_t       shadow_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               en_o,
  output logic [FLAG_W-1:0]  flags_o
);

  logic [COORD_W-1:0] sh_x_q, sh_y_q, act_x_q, act_y_q;
  logic               sh_en_q, act_en_q;
  logic [FLAG_W-1:0]  sh_flags_q, act_flags_q;

  // Shadow registers: loaded by bus writes only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_en_q    <= 1'b0;
      sh_flags_q <= '0;
    end else begin
      if (wr_pos_i) begin
        sh_x_q <= x_i;
        sh_y_q <= y_i;
      end
      if (wr_attr_i) begin
        sh_en_q    <= en_i;
        sh_flags_q <= flags_i;
      end
    end
  end

  // Active registers: take the whole shadow at once on commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_en_q    <= 1'b0;
      act_flags_q <= '0;
    end else if (commit_i) begin
      act_x_q     <= sh_x_q;
      act_y_q     <= sh_y_q;
      act_en_q    <= sh_en_q;
      act_flags_q <= sh_flags_q;
    end
  end

  // Zero-extended shadow view for bus readback.
  always_comb begin
    shadow_o                    = '0;
    shadow_o.x[COORD_W-1:0]     = sh_x_q;
    shadow_o.y[COORD_W-1:0]     = sh_y_q;
    shadow_o.en                 = sh_en_q;
    shadow_o.flags[FLAG_W-1:0]  = sh_flags_q;
  end

  assign x_o     = act_x_q;
  assign y_o     = act_y_q;
  assign en_o    = act_en_q;
  assign flags_o = act_flags_q;

endmodule

// File: rtl/sprite_attr_bank.sv
// Avalon-MM sprite attribute bank: shadow registers committed atomically to
// the compositor outputs at a vblank rising edge or on CPU request.
// Optional: define SPRITE_BANK_IRQ_EN for the irq output and CTRL.irq_enable.
module sprite_attr_bank
  import sprite_bank_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned FLAG_W      = 4,
  parameter int unsigned ADDR_W      = $clog2(4 + 2 * NUM_SPRITES)
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [ADDR_W-1:0]              avs_address,
  input  logic                           avs_write,
  input  logic [31:0]                    avs_writedata,
  input  logic                           avs_read,
  output logic [31:0]                    avs_readdata,
  output logic                           avs_readdatavalid,
  input  logic                           frame_sync_in,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_x_export,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_y_export,
  output logic [NUM_SPRITES-1:0]         sprite_en_export,
  output logic [NUM_SPRITES*FLAG_W-1:0]  sprite_flags_export,
  output logic [15:0]                    frame_count_export
`ifdef SPRITE_BANK_IRQ_EN
  ,
  output logic                           irq
`endif
);

  logic [31:0] addr_w;
  logic        ctrl_wr, status_wr, commit_now, fs_rise, commit, spr_wr_any;
  logic [NUM_SPRITES-1:0] wr_pos, wr_attr;
  sprite_attr_t shadow [NUM_SPRITES];

  logic        fs_q;
  logic        auto_commit_q, auto_commit_d;
  logic        pending_q, pending_d;
  logic        irq_flag_q, irq_flag_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] readdata_q, readdata_d, rd_mux;
  logic        rvalid_q, rvalid_d;
  logic        irq_en;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign addr_w     = 32'(avs_address);
  assign ctrl_wr    = avs_write && (addr_w == ADDR_CTRL);
  assign status_wr  = avs_write && (addr_w == ADDR_STATUS);
  assign commit_now = ctrl_wr && avs_writedata[CTRL_COMMIT_BIT];
  assign fs_rise    = frame_sync_in & ~fs_q;
  assign commit     = (fs_rise & auto_commit_q & pending_q) | commit_now;
  assign spr_wr_any = (|wr_pos) | (|wr_attr);

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    assign wr_pos[g]  = avs_write && (addr_w == pos_addr(g));
    assign wr_attr[g] = avs_write && (addr_w == attr_addr(g));

    sprite_entry #(
      .COORD_W (COORD_W),
      .FLAG_W  (FLAG_W)
    ) u_entry (
      .clk_i     (clk_clk),
      .rst_ni    (reset_reset_n),
      .wr_pos_i  (wr_pos[g]),
      .wr_attr_i (wr_attr[g]),
      .commit_i  (commit),
      .x_i       (avs_writedata[COORD_W-1:0]),
      .y_i       (avs_writedata[16 +: COORD_W]),
      .en_i      (avs_writedata[0]),
      .flags_i   (avs_writedata[1 +: FLAG_W]),
      .shadow_o  (shadow[g]),
      .x_o       (sprite_x_export[g*COORD_W +: COORD_W]),
      .y_o       (sprite_y_export[g*COORD_W +: COORD_W]),
      .en_o      (sprite_en_export[g]),
      .flags_o   (sprite_flags_export[g*FLAG_W +: FLAG_W])
    );
  end

`ifdef SPRITE_BANK_IRQ_EN
  logic irq_en_q, irq_en_d;

  // irq_enable control bit.
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = avs_writedata[CTRL_IRQEN_BIT];
  end

  // irq_enable register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq_en_q <= 1'b0;
    else                irq_en_q <= irq_en_d;
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_flag_q & irq_en_q;
`else
  assign irq_en = 1'b0;
`endif

  // Readback mux over control registers and sprite shadows.
  always_comb begin
    rd_mux = '0;
    if (addr_w == ADDR_CTRL) begin
      rd_mux[CTRL_AUTO_BIT]  = auto_commit_q;
      rd_mux[CTRL_IRQEN_BIT] = irq_en;
    end else if (addr_w == ADDR_STATUS) begin
      rd_mux[STAT_PEND_BIT] = pending_q;
      rd_mux[STAT_IRQ_BIT]  = irq_flag_q;
    end else if (addr_w == ADDR_FCOUNT) begin
      rd_mux[15:0] = frame_count_q;
    end
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (addr_w == pos_addr(i))  rd_mux = {shadow[i].y, shadow[i].x};
      if (addr_w == attr_addr(i)) rd_mux = {16'h0000, shadow[i].flags, shadow[i].en};
    end
  end

  // Control/status next state. Later assignments win: a sprite write keeps
  // pending set across a commit, and a commit beats a same-cycle irq clear.
  always_comb begin
    auto_commit_d = auto_commit_q;
    if (ctrl_wr) auto_commit_d = avs_writedata[CTRL_AUTO_BIT];

    pending_d = pending_q;
    if (commit)     pending_d = 1'b0;
    if (spr_wr_any) pending_d = 1'b1;

    irq_flag_d = irq_flag_q;
    if (status_wr && avs_writedata[STAT_IRQ_BIT]) irq_flag_d = 1'b0;
    if (commit)                                   irq_flag_d = 1'b1;

    frame_count_d = commit ? frame_count_q + 16'd1 : frame_count_q;

    rvalid_d   = avs_read;
    readdata_d = avs_read ? rd_mux : readdata_q;
  end

  // Control, status and read-response registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fs_q          <= 1'b0;
      auto_commit_q <= 1'b1;
      pending_q     <= 1'b0;
      irq_flag_q    <= 1'b0;
      frame_count_q <= '0;
      readdata_q    <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      fs_q          <= frame_sync_in;
      auto_commit_q <= auto_commit_d;
      pending_q     <= pending_d;
      irq_flag_q    <= irq_flag_d;
      frame_count_q <= frame_count_d;
      readdata_q    <= readdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign avs_readdata       = readdata_q;
  assign avs_readdatavalid  = rvalid_q;
  assign frame_count_export = frame_count_q;

endmodule

// File: tb/tb_sprite_attr_bank.sv
// Directed self-checking bench for sprite_attr_bank (default parameters).
// Covers the SPRITE_BANK_IRQ_EN variant when that macro is defined.
module tb_sprite_attr_bank;

  localparam int unsigned NS = 8;
  localparam int unsigned CW = 10;
  localparam int unsigned FW = 4;
  localparam int unsigned AW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              frame_sync_in = 1'b0;
  logic [NS*CW-1:0]  sprite_x_export, sprite_y_export;
  logic [NS-1:0]     sprite_en_export;
  logic [NS*FW-1:0]  sprite_flags_export;
  logic [15:0]       frame_count_export;
`ifdef SPRITE_BANK_IRQ_EN
  logic              irq;
`endif

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  sprite_attr_bank #(
    .NUM_SPRITES (NS),
    .COORD_W     (CW),
    .FLAG_W      (FW)
  ) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rst_n),
    .avs_address         (avs_address),
    .avs_write           (avs_write),
    .avs_writedata       (avs_writedata),
    .avs_read            (avs_read),
    .avs_readdata        (avs_readdata),
    .avs_readdatavalid   (avs_readdatavalid),
    .frame_sync_in       (frame_sync_in),
    .sprite_x_export     (sprite_x_export),
    .sprite_y_export     (sprite_y_export),
    .sprite_en_export    (sprite_en_export),
    .sprite_flags_export (sprite_flags_export),
    .frame_count_export  (frame_count_export)
`ifdef SPRITE_BANK_IRQ_EN
    ,
    .irq                 (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xs(input int i);
    return 32'(sprite_x_export[i*CW +: CW]);
  endfunction

  function automatic logic [31:0] ys(input int i);
    return 32'(sprite_y_export[i*CW +: CW]);
  endfunction

  function automatic logic [31:0] fl(input int i);
    return 32'(sprite_flags_export[i*FW +: FW]);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input int a, input logic [31:0] d);
    avs_address   = AW'(a);
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk); #1;
    avs_write     = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    avs_address = AW'(a);
    avs_read    = 1'b1;
    @(posedge clk); #1;
    avs_read    = 1'b0;
    check({tag, "_rvalid"}, 32'(avs_readdatavalid), 32'd1);
    check(tag, avs_readdata, exp);
  endtask

  task automatic fs_pulse();
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    frame_sync_in = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values while reset is held.
    #13;
    check("rst_x", sprite_x_export[31:0], 32'd0);
    check("rst_en", 32'(sprite_en_export), 32'd0);
    check("rst_fc", 32'(frame_count_export), 32'd0);
    check("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1, 32'h0, "rst_status");
    rd(0, 32'h1, "rst_ctrl");
    rd(2, 32'h0, "rst_fcount");

    // Shadow write, then auto commit on vblank rise.
    wr(4, 32'h0064_0032);
    wr(5, 32'h0000_0003);
    check("pre_commit_x0", xs(0), 32'h0);
    check("pre_commit_en", 32'(sprite_en_export), 32'h0);
    rd(1, 32'h1, "status_pending");
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    exp_fc++;
    check("commit_x0", xs(0), 32'h32);
    check("commit_y0", ys(0), 32'h64);
    check("commit_en", 32'(sprite_en_export), 32'h1);
    check("commit_fl0", fl(0), 32'h1);
    check("commit_fc", 32'(frame_count_export), 32'(exp_fc));
    frame_sync_in = 1'b0;
    @(posedge clk); #1;
    rd(1, 32'h2, "status_after_commit");
    wr(1, 32'h2);
    rd(1, 32'h0, "status_w1c");

    // auto_commit off: vblank ignored, commit_now forces the commit.
    wr(0, 32'h0);
    wr(6, 32'hFD23_FC45);
    rd(6, 32'h0123_0045, "pos1_unused_bits");
    fs_pulse();
    check("noauto_x1", xs(1), 32'h0);
    check("noauto_fc", 32'(frame_count_export), 32'(exp_fc));
    wr(0, 32'h2);
    exp_fc++;
    check("cnow_x1", xs(1), 32'h45);
    check("cnow_y1", ys(1), 32'h123);
    check("cnow_fc", 32'(frame_count_export), 32'(exp_fc));
    rd(0, 32'h0, "ctrl_cnow_reads0");
    wr(0, 32'h1);

    // Sprite write in the same cycle as a vblank commit.
    wr(10, 32'h0007_0008);
    avs_address   = AW'(9);
    avs_writedata = 32'h5;
    avs_write     = 1'b1;
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    avs_write     = 1'b0;
    exp_fc++;
    check("coinc_x3", xs(3), 32'h8);
    check("coinc_en2", 32'(sprite_en_export[2]), 32'h0);
    check("coinc_fc", 32'(frame_count_export), 32'(exp_fc));
    frame_sync_in = 1'b0;
    @(posedge clk); #1;
    rd(1, 32'h3, "coinc_pending");
    rd(9, 32'h5, "coinc_shadow");
    fs_pulse();
    exp_fc++;
    check("next_en2", 32'(sprite_en_export[2]), 32'h1);
    check("next_fl2", fl(2), 32'h2);
    check("next_fc", 32'(frame_count_export), 32'(exp_fc));

    // Readback latency and unmapped addresses.
    rd(4, 32'h0064_0032, "rd_pos0");
    @(posedge clk); #1;
    check("rvalid_drop", 32'(avs_readdatavalid), 32'd0);
    rd(3, 32'h0, "rd_reserved");
    rd(20, 32'h0, "rd_beyond");
    rd(31, 32'h0, "rd_top");
    wr(20, 32'hFFFF_FFFF);
    rd(1, 32'h2, "wr_beyond_ignored");

    // commit_now together with a vblank commit: one increment.
    wr(12, 32'h0002_0001);
    avs_address   = AW'(0);
    avs_writedata = 32'h3;
    avs_write     = 1'b1;
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    avs_write     = 1'b0;
    frame_sync_in = 1'b0;
    exp_fc++;
    @(posedge clk); #1;
    check("dual_fc", 32'(frame_count_export), 32'(exp_fc));
    check("dual_x4", xs(4), 32'h1);

    // Held vblank produces one rise only.
    wr(4, 32'h0001_0002);
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    exp_fc++;
    check("held_x0", xs(0), 32'h2);
    wr(4, 32'h0003_0004);
    @(posedge clk); #1;
    check("held_x0_stay", xs(0), 32'h2);
    check("held_fc", 32'(frame_count_export), 32'(exp_fc));
    frame_sync_in = 1'b0;
    @(posedge clk); #1;
    fs_pulse();
    exp_fc++;
    check("held_release_x0", xs(0), 32'h4);
    check("held_release_fc", 32'(frame_count_export), 32'(exp_fc));

    // frame_count wrap via back-to-back commit_now writes.
    avs_address   = AW'(0);
    avs_writedata = 32'h3;
    avs_write     = 1'b1;
    repeat (65535 - exp_fc) @(posedge clk);
    #1;
    check("fc_max", 32'(frame_count_export), 32'h0000_FFFF);
    @(posedge clk); #1;
    avs_write = 1'b0;
    check("fc_wrap", 32'(frame_count_export), 32'h0);
    exp_fc = 0;

    // irq_flag clear coincident with a commit: flag stays set.
    wr(1, 32'h2);
    rd(1, 32'h0, "w1c_clear");
    wr(8, 32'h0005_0006);
    avs_address   = AW'(1);
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    avs_write     = 1'b0;
    frame_sync_in = 1'b0;
    exp_fc++;
    @(posedge clk); #1;
    rd(1, 32'h2, "w1c_vs_commit");
    check("w1c_fc", 32'(frame_count_export), 32'(exp_fc));

`ifdef SPRITE_BANK_IRQ_EN
    wr(0, 32'h5);
    rd(0, 32'h5, "ctrl_irqen");
    check("irq_on", 32'(irq), 32'h1);
    wr(1, 32'h2);
    check("irq_cleared", 32'(irq), 32'h0);
    wr(0, 32'h7);
    check("irq_cnow", 32'(irq), 32'h1);
    wr(8, 32'h0001_0001);
    avs_address   = AW'(1);
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    frame_sync_in = 1'b1;
    @(posedge clk); #1;
    avs_write     = 1'b0;
    frame_sync_in = 1'b0;
    check("irq_w1c_vs_commit", 32'(irq), 32'h1);
    @(posedge clk); #1;
`else
    wr(0, 32'h5);
    rd(0, 32'h1, "ctrl_bit2_ignored");
`endif

    // Asynchronous reset between clock edges.
    wr(4, 32'h0011_0022);
    #3 rst_n = 1'b0;
    #1;
    check("arst_fc", 32'(frame_count_export), 32'h0);
    check("arst_x", sprite_x_export[31:0], 32'h0);
    check("arst_en", 32'(sprite_en_export), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(0, 32'h1, "arst_ctrl");
    rd(1, 32'h0, "arst_status");
    rd(4, 32'h0, "arst_shadow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
